// File: rtl/fft_sample_buffer.sv
// Sample/result memory between the AXI bridge and the FFT core, plus the frame FSM.
// Optional macro FFT_BITREV_LOAD_EN: bridge loads are stored at bit-reversed addresses.
module fft_sample_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int DEPTH        = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_WRITE_ram,
    input  logic                  i_READ_ram,
    input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE_ram,
    input  logic [ADDR_WIDTH-1:0] i_SAMPLE_INDEX_ram,
    input  logic                  i_DATA_LOADED,
    output logic [DATA_WIDTH-1:0] o_DATA_FROM_RAM,
    output logic [ADDR_WIDTH-1:0] o_SAMPLES_NUMBER,
    output logic                  o_CALC_END,
    output logic                  o_CORE_START,
    input  logic                  i_CORE_RD_EN,
    input  logic [ADDR_WIDTH-1:0] i_CORE_RD_ADDR,
    output logic [DATA_WIDTH-1:0] o_CORE_RD_DATA,
    output logic                  o_CORE_RD_VALID,
    input  logic                  i_CORE_WR_EN,
    input  logic [ADDR_WIDTH-1:0] i_CORE_WR_ADDR,
    input  logic [DATA_WIDTH-1:0] i_CORE_WR_DATA,
    input  logic                  i_CORE_DONE,
    output logic                  o_BUSY,
    output logic                  o_ERR
);

    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_CALC,
        S_UNLOAD
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_samples_number;
    logic                  r_calc_end;
    logic                  r_core_start;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_in_load;
    logic                  w_in_start;
    logic                  w_in_calc;
    logic                  w_in_unload;
    logic                  w_br_idx_ok;
    logic                  w_crd_ok;
    logic                  w_cwr_ok;
    logic [CW-1:0]         w_idx_p1;
    logic [CW-1:0]         w_count_max;
    logic [CW-1:0]         w_load_count;
    logic                  w_br_wr;
    logic                  w_core_rd;
    logic                  w_core_wr;
    logic                  w_err_evt;
    logic [MAW-1:0]        w_load_addr;
    logic                  w_mem_we;
    logic [MAW-1:0]        w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_br_rd_data;

`ifdef FFT_BITREV_LOAD_EN
    function automatic logic [MAW-1:0] f_bitrev(input logic [MAW-1:0] a);
        logic [MAW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAW; i++) begin
            r[i] = a[MAW-1-i];
        end
        return r;
    endfunction

    assign w_load_addr = f_bitrev(i_SAMPLE_INDEX_ram[MAW-1:0]);
`else
    assign w_load_addr = i_SAMPLE_INDEX_ram[MAW-1:0];
`endif

    assign w_in_load   = (r_state == S_LOAD);
    assign w_in_start  = (r_state == S_START);
    assign w_in_calc   = (r_state == S_CALC);
    assign w_in_unload = (r_state == S_UNLOAD);

    assign w_br_idx_ok = ({1'b0, i_SAMPLE_INDEX_ram} < DEPTH_C);
    assign w_crd_ok    = ({1'b0, i_CORE_RD_ADDR} < DEPTH_C);
    assign w_cwr_ok    = ({1'b0, i_CORE_WR_ADDR} < DEPTH_C);

    assign w_idx_p1     = {1'b0, i_SAMPLE_INDEX_ram} + CW'(1);
    assign w_count_max  = (w_idx_p1 > r_count) ? w_idx_p1 : r_count;

    assign w_br_wr   = i_WRITE_ram && w_br_idx_ok && (w_in_load || w_in_unload);
    assign w_core_rd = w_in_calc && i_CORE_RD_EN && w_crd_ok;
    assign w_core_wr = w_in_calc && i_CORE_WR_EN && w_cwr_ok;

    // Count seen by DATA_LOADED includes a write landing in the same cycle.
    assign w_load_count = w_br_wr ? w_count_max : r_count;

    always_comb begin
        w_err_evt = 1'b0;
        if (w_in_load || w_in_unload) begin
            w_err_evt = (i_WRITE_ram && !w_br_idx_ok) || i_CORE_RD_EN || i_CORE_WR_EN;
        end else if (w_in_start) begin
            w_err_evt = i_WRITE_ram || i_READ_ram || i_CORE_RD_EN || i_CORE_WR_EN;
        end else begin
            w_err_evt = i_WRITE_ram || i_READ_ram
                     || (i_CORE_RD_EN && !w_crd_ok) || (i_CORE_WR_EN && !w_cwr_ok);
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = '0;
        w_mem_wdata = '0;
        if (w_br_wr) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = w_load_addr;
            w_mem_wdata = {i_SAMPLE_ram, {(DATA_WIDTH-SAMPLE_WIDTH){1'b0}}};
        end else if (w_core_wr) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = i_CORE_WR_ADDR[MAW-1:0];
            w_mem_wdata = i_CORE_WR_DATA;
        end
    end

    always_comb begin
        w_br_rd_data = '0;
        if (w_in_unload && i_READ_ram && ({1'b0, i_SAMPLE_INDEX_ram} < r_count)) begin
            w_br_rd_data = r_mem[i_SAMPLE_INDEX_ram[MAW-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state          <= S_LOAD;
            r_count          <= '0;
            r_samples_number <= '0;
            r_calc_end       <= 1'b0;
            r_core_start     <= 1'b0;
            r_busy           <= 1'b0;
            r_err            <= 1'b0;
            r_rd_valid       <= 1'b0;
            r_rd_data        <= '0;
        end else begin
            r_core_start <= 1'b0;
            r_rd_valid   <= w_core_rd;
            if (w_core_rd) begin
                r_rd_data <= r_mem[i_CORE_RD_ADDR[MAW-1:0]];
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_LOAD: begin
                    r_count <= w_load_count;
                    if (i_DATA_LOADED && (w_load_count != '0)) begin
                        r_state          <= S_START;
                        r_core_start     <= 1'b1;
                        r_busy           <= 1'b1;
                        r_samples_number <= w_load_count[ADDR_WIDTH-1:0];
                    end
                end
                S_START: begin
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    if (i_CORE_DONE) begin
                        r_state    <= S_UNLOAD;
                        r_busy     <= 1'b0;
                        r_calc_end <= 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (w_br_wr) begin
                        r_state    <= S_LOAD;
                        r_calc_end <= 1'b0;
                        r_count    <= w_idx_p1;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign o_DATA_FROM_RAM  = w_br_rd_data;
    assign o_SAMPLES_NUMBER = r_samples_number;
    assign o_CALC_END       = r_calc_end;
    assign o_CORE_START     = r_core_start;
    assign o_CORE_RD_DATA   = r_rd_data;
    assign o_CORE_RD_VALID  = r_rd_valid;
    assign o_BUSY           = r_busy;
    assign o_ERR            = r_err;

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Directed table-driven bench for fft_sample_buffer (DEPTH=8); expectations follow
// FFT_BITREV_LOAD_EN through the load-address map function m().
module tb_fft_sample_buffer;

    logic        clk;
    logic        rstn;
    logic        wr, rd, ld, crd, cwr, done;
    logic [11:0] idx, cra, cwa;
    logic [15:0] smp;
    logic [31:0] cwd;
    logic [31:0] dout, rdd;
    logic [11:0] num;
    logic        cend, start, val, busy, err;

    int n_cmp;
    int n_bad;

    fft_sample_buffer #(
        .DATA_WIDTH   (32),
        .SAMPLE_WIDTH (16),
        .ADDR_WIDTH   (12),
        .DEPTH        (8)
    ) dut (
        .i_clk              (clk),
        .i_rstn             (rstn),
        .i_WRITE_ram        (wr),
        .i_READ_ram         (rd),
        .i_SAMPLE_ram       (smp),
        .i_SAMPLE_INDEX_ram (idx),
        .i_DATA_LOADED      (ld),
        .o_DATA_FROM_RAM    (dout),
        .o_SAMPLES_NUMBER   (num),
        .o_CALC_END         (cend),
        .o_CORE_START       (start),
        .i_CORE_RD_EN       (crd),
        .i_CORE_RD_ADDR     (cra),
        .o_CORE_RD_DATA     (rdd),
        .o_CORE_RD_VALID    (val),
        .i_CORE_WR_EN       (cwr),
        .i_CORE_WR_ADDR     (cwa),
        .i_CORE_WR_DATA     (cwd),
        .i_CORE_DONE        (done),
        .o_BUSY             (busy),
        .o_ERR              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr, rd;
        logic [11:0] idx;
        logic [15:0] smp;
        logic        ld, crd;
        logic [11:0] cra;
        logic        cwr;
        logic [11:0] cwa;
        logic [31:0] cwd;
        logic        done;
        logic [31:0] e_data;
        logic        e_start, e_busy, e_cend, e_err;
        logic [11:0] e_num;
        logic        e_val;
        logic [31:0] e_rdd;
    } vec_t;

    vec_t vecs[$];

    // Physical address a loaded sample lands at (bit-reverse is its own inverse).
    function automatic logic [11:0] m(input int unsigned i);
        logic [2:0] b;
        b = i[2:0];
`ifdef FFT_BITREV_LOAD_EN
        return {9'd0, b[0], b[1], b[2]};
`else
        return {9'd0, b};
`endif
    endfunction

    function automatic logic [31:0] sv(input logic [11:0] v);
        return {4'd0, v, 16'h0000};
    endfunction

    task automatic add(input string name, input logic w, input logic r, input logic [11:0] i,
                       input logic [15:0] s, input logic l, input logic cr, input logic [11:0] ca,
                       input logic cw, input logic [11:0] wa, input logic [31:0] wd, input logic dn,
                       input logic [31:0] ed, input logic es, input logic eb, input logic ec,
                       input logic ee, input logic [11:0] en, input logic ev, input logic [31:0] er);
        vec_t v;
        v.name = name; v.wr = w; v.rd = r; v.idx = i; v.smp = s; v.ld = l;
        v.crd = cr; v.cra = ca; v.cwr = cw; v.cwa = wa; v.cwd = wd; v.done = dn;
        v.e_data = ed; v.e_start = es; v.e_busy = eb; v.e_cend = ec; v.e_err = ee;
        v.e_num = en; v.e_val = ev; v.e_rdd = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr = 0; rd = 0; idx = '0; smp = '0; ld = 0;
        crd = 0; cra = '0; cwr = 0; cwa = '0; cwd = '0; done = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, ".data"},  dout, 32'h0);
        chk({tag, ".num"},   {20'd0, num}, 32'h0);
        chk({tag, ".cend"},  {31'd0, cend}, 32'h0);
        chk({tag, ".start"}, {31'd0, start}, 32'h0);
        chk({tag, ".valid"}, {31'd0, val}, 32'h0);
        chk({tag, ".busy"},  {31'd0, busy}, 32'h0);
        chk({tag, ".err"},   {31'd0, err}, 32'h0);
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic apply(input vec_t v);
        wr = v.wr; rd = v.rd; idx = v.idx; smp = v.smp; ld = v.ld;
        crd = v.crd; cra = v.cra; cwr = v.cwr; cwa = v.cwa; cwd = v.cwd; done = v.done;
        #1;
        chk({v.name, ".data"}, dout, v.e_data);
        @(posedge clk);
        #1;
        chk({v.name, ".start"}, {31'd0, start}, {31'd0, v.e_start});
        chk({v.name, ".busy"},  {31'd0, busy},  {31'd0, v.e_busy});
        chk({v.name, ".cend"},  {31'd0, cend},  {31'd0, v.e_cend});
        chk({v.name, ".err"},   {31'd0, err},   {31'd0, v.e_err});
        chk({v.name, ".num"},   {20'd0, num},   {20'd0, v.e_num});
        chk({v.name, ".valid"}, {31'd0, val},   {31'd0, v.e_val});
        if (v.e_val) chk({v.name, ".rddata"}, rdd, v.e_rdd);
    endtask

    task automatic run_table();
        for (int k = 0; k < vecs.size(); k++) apply(vecs[k]);
        vecs.delete();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        //  name         wr rd idx     smp       ld crd cra    cwr cwa   cwd            dn  e_data          st bs ce er num  ev e_rdd
        add("ld_empty",  0, 0, 12'd0,  16'd0,    1, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd0, 0, 32'h0);
        add("w0",        1, 0, 12'd0,  16'd1,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd0, 0, 32'h0);
        add("w1",        1, 0, 12'd1,  16'd2,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd0, 0, 32'h0);
        add("w2",        1, 0, 12'd2,  16'd3,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd0, 0, 32'h0);
        add("w7",        1, 0, 12'd7,  16'd8,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd0, 0, 32'h0);
        add("w3",        1, 0, 12'd3,  16'd4,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd0, 0, 32'h0);
        add("w4",        1, 0, 12'd4,  16'd5,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd0, 0, 32'h0);
        add("w5",        1, 0, 12'd5,  16'd6,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd0, 0, 32'h0);
        add("w6_ld",     1, 0, 12'd6,  16'd7,    1, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           1, 1, 0, 0, 12'd8, 0, 32'h0);
        add("start_end", 0, 0, 12'd0,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 0, 12'd8, 0, 32'h0);
        add("crd3",      0, 0, 12'd0,  16'd0,    0, 1, 12'd3, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 0, 12'd8, 1, sv(m(3) + 12'd1));
        add("no_rd",     0, 0, 12'd0,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 0, 12'd8, 0, 32'h0);
        add("crd6",      0, 0, 12'd0,  16'd0,    0, 1, 12'd6, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 0, 12'd8, 1, sv(m(6) + 12'd1));
        add("rw2_old",   0, 0, 12'd0,  16'd0,    0, 1, 12'd2, 1, 12'd2, 32'h1234_5678,  0, 32'h0,           0, 1, 0, 0, 12'd8, 1, sv(m(2) + 12'd1));
        add("rd2_new",   0, 0, 12'd0,  16'd0,    0, 1, 12'd2, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 0, 12'd8, 1, 32'h1234_5678);
        add("wr5_done",  0, 0, 12'd0,  16'd0,    0, 1, 12'd5, 1, 12'd5, 32'hDEAD_BEEF,  1, 32'h0,           0, 0, 1, 0, 12'd8, 1, sv(m(5) + 12'd1));
        add("brd5",      0, 1, 12'd5,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'hDEAD_BEEF,   0, 0, 1, 0, 12'd8, 0, 32'h0);
        add("brd2",      0, 1, 12'd2,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h1234_5678,   0, 0, 1, 0, 12'd8, 0, 32'h0);
        add("brd0",      0, 1, 12'd0,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0001_0000,   0, 0, 1, 0, 12'd8, 0, 32'h0);
        add("brd9_oob",  0, 1, 12'd9,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 1, 0, 12'd8, 0, 32'h0);
        add("brd_nostb", 0, 0, 12'd5,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 1, 0, 12'd8, 0, 32'h0);
        add("new_frame", 1, 0, 12'd2,  16'hAAAA, 0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 0, 12'd8, 0, 32'h0);
        add("ld2",       0, 0, 12'd0,  16'd0,    1, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           1, 1, 0, 0, 12'd3, 0, 32'h0);
        add("start2_end",0, 0, 12'd0,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 0, 12'd3, 0, 32'h0);
        add("crd_new2",  0, 0, 12'd0,  16'd0,    0, 1, m(2),  0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 0, 12'd3, 1, 32'hAAAA_0000);
        add("bwr_calc",  1, 0, 12'd1,  16'h7777, 0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 1, 12'd3, 0, 32'h0);
        add("crd1_keep", 0, 0, 12'd0,  16'd0,    0, 1, 12'd1, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 1, 12'd3, 1, sv(m(1) + 12'd1));
        run_table();

        rstn = 1'b0;
        #1;
        check_zero_outputs("rst_calc");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        add("oob_wr",    1, 0, 12'd8,  16'h0055, 0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 1, 12'd0, 0, 32'h0);
        add("ld_after",  0, 0, 12'd0,  16'd0,    1, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 1, 12'd0, 0, 32'h0);
        add("crd_load",  0, 0, 12'd0,  16'd0,    0, 1, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 0, 0, 1, 12'd0, 0, 32'h0);
        add("w1_ld",     1, 0, 12'd1,  16'd7,    1, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           1, 1, 0, 1, 12'd2, 0, 32'h0);
        add("start3_end",0, 0, 12'd0,  16'd0,    0, 0, 12'd0, 0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 1, 12'd2, 0, 32'h0);
        add("crd_map1",  0, 0, 12'd0,  16'd0,    0, 1, m(1),  0, 12'd0, 32'h0,          0, 32'h0,           0, 1, 0, 1, 12'd2, 1, 32'h0007_0000);
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
